poly_voice_alloc: RTL

//  Polyphonic successor to the single GATE/LAST_NOTE path of the mono synth top. Consumes the
//  one-cycle channel-message strobe from midi_in and assigns note-on/off events to VOICES slots.

---
 rtl/poly_voice_alloc.sv | 125 ++++++++++++
 1 files changed

// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator. Maps MIDI note on/off strobes onto VOICES gate/note/velocity slots.
// A slot is chosen by same-note retrigger first, then the least recently used free slot, then by stealing the LRU slot.
module poly_voice_alloc #(
  parameter int unsigned VOICES    = 4,
  parameter int unsigned DRUM_CHAN = 9,
  parameter bit          OMNI      = 1'b1,
  parameter int unsigned RX_CHAN   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           ch_message,
  input  logic [3:0]           chan,
  input  logic [6:0]           note,
  input  logic [6:0]           velocity,
  input  logic [6:0]           lsb,
  output logic [VOICES-1:0]    gate,
  output logic [7*VOICES-1:0]  note_out,
  output logic [7*VOICES-1:0]  vel_out,
  output logic [VOICES-1:0]    retrig,
  output logic                 steal
);
  localparam int unsigned AW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int unsigned NW = 7;

  logic [AW-1:0]        age   [VOICES];
  logic [AW-1:0]        age_d [VOICES];
  logic [VOICES-1:0]    gate_d;
  logic [VOICES-1:0]    retrig_d;
  logic [NW*VOICES-1:0] note_d;
  logic [NW*VOICES-1:0] vel_d;
  logic                 steal_d;
  logic                 accept;
  logic                 ev_on;
  logic                 ev_off;
  logic                 ev_all_off;
  logic                 hit_found;
  logic                 free_found;
  logic [AW-1:0]        hit_idx;
  logic [AW-1:0]        free_idx;
  logic [AW-1:0]        free_age;
  logic [AW-1:0]        old_idx;
  logic [AW-1:0]        tgt_idx;
  logic [AW-1:0]        tgt_age;

  assign accept     = OMNI ? (chan != 4'(DRUM_CHAN)) : (chan == 4'(RX_CHAN));
  assign ev_on      = accept && (ch_message == 4'b1001) && (velocity != 7'd0);
  assign ev_off     = accept && ((ch_message == 4'b1000) ||
                                 ((ch_message == 4'b1001) && (velocity == 7'd0)));
  assign ev_all_off = accept && (ch_message == 4'b1011) && (lsb == 7'd123);

  // Parallel candidate search: same-note hit, oldest free slot, and the LRU slot.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    free_age   = '0;
    old_idx    = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (gate[i] && (note_out[NW*i +: NW] == note)) begin
        hit_found = 1'b1;
        hit_idx   = AW'(i);
      end
    end
    for (int i = 0; i < VOICES; i++) begin
      if (!gate[i] && (!free_found || (age[i] > free_age))) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
        free_age   = age[i];
      end
      if (age[i] == AW'(VOICES - 1)) old_idx = AW'(i);
    end
    tgt_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    tgt_age = age[tgt_idx];
  end

  // Next-state for slots and LRU ages.
  always_comb begin
    gate_d   = gate;
    note_d   = note_out;
    vel_d    = vel_out;
    retrig_d = '0;
    steal_d  = 1'b0;
    for (int i = 0; i < VOICES; i++) age_d[i] = age[i];
    if (ev_on) begin
      steal_d = !hit_found && !free_found;
      for (int i = 0; i < VOICES; i++) begin
        if (AW'(i) == tgt_idx) begin
          gate_d[i]            = 1'b1;
          note_d[NW*i +: NW]   = note;
          vel_d[NW*i +: NW]    = velocity;
          retrig_d[i]          = 1'b1;
          age_d[i]             = '0;
        end else if (age[i] < tgt_age) begin
          age_d[i] = age[i] + AW'(1);
        end
      end
    end else if (ev_off) begin
      for (int i = 0; i < VOICES; i++) begin
        if (gate[i] && (note_out[NW*i +: NW] == note)) gate_d[i] = 1'b0;
      end
    end else if (ev_all_off) begin
      gate_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate     <= '0;
      note_out <= '0;
      vel_out  <= '0;
      retrig   <= '0;
      steal    <= 1'b0;
      for (int i = 0; i < VOICES; i++) age[i] <= AW'(VOICES - 1 - i);
    end else begin
      gate     <= gate_d;
      note_out <= note_d;
      vel_out  <= vel_d;
      retrig   <= retrig_d;
      steal    <= steal_d;
      for (int i = 0; i < VOICES; i++) age[i] <= age_d[i];
    end
  end

endmodule
